// File: rtl/hc595_pkg.sv
// hc595_pkg: shared types and default parameters for the 74HC595 serial driver.
//   state_t      : frame sequencer states (LOAD -> SHIFT -> GAP -> LOAD)
//   DEF_DATA_W   : default bits per frame
//   DEF_CLK_DIV  : default clk cycles per shcp period (even, >= 2)
//   DEF_GAP_CYC  : default idle cycles after the last bit of a frame (>= 1)
package hc595_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_GAP_CYC = 16;

endpackage

// File: rtl/hc595_if.sv
// hc595_if: bundle between the core logic and the shift-register pin driver.
//   din  : parallel word to transmit (core -> driver)
//   shcp : shift clock to the HC595 SH_CP pin (driver -> board)
//   ds   : serial data to the HC595 DS pin (driver -> board)
// Modports:
//   master : core side, drives din and may observe the pin outputs
//   slave  : driver side, takes din and drives shcp/ds
interface hc595_if
  import hc595_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] din;
  logic              shcp;
  logic              ds;

  modport master (output din, input shcp, input ds);
  modport slave  (input din, output shcp, output ds);

endinterface

// File: rtl/hc595_tick.sv
// hc595_tick: phase counter for one shcp period.
//   clk        : system clock
//   srst       : synchronous active-high reset
//   en         : count while high; phase is held at 0 while low
//   bit_start  : strobe at phase 0 (new bit is presented on ds)
//   shcp_rise  : strobe at phase CLK_DIV/2 (mid-bit shcp rising edge)
//   phase_last : strobe at phase CLK_DIV-1 (bit period ends on this edge)
module hc595_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  output logic bit_start,
  output logic shcp_rise,
  output logic phase_last
);

  localparam int PH_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [PH_W-1:0] phase_reg;
  logic [PH_W-1:0] phase_next;

  always_comb begin
    phase_next = phase_reg;
    if (!en) begin
      phase_next = '0;
    end else if (phase_reg == PH_W'(CLK_DIV - 1)) begin
      phase_next = '0;
    end else begin
      phase_next = phase_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

  assign bit_start  = en && (phase_reg == '0);
  assign shcp_rise  = en && (phase_reg == PH_W'(CLK_DIV / 2));
  assign phase_last = en && (phase_reg == PH_W'(CLK_DIV - 1));

endmodule

// File: rtl/hc595.sv
// hc595: serial driver for a 74HC595-style shift-register chain.
// Captures din once per frame and shifts it out MSB-first on ds with shift
// clock shcp, then idles for GAP_CYC cycles. Frame = 1 + DATA_W*CLK_DIV + GAP_CYC.
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, ACTIVE-HIGH despite its name
//   bus   : hc595_if slave modport (din in; shcp, ds out, both registered)
module hc595
  import hc595_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input logic    clk,
  input logic    rst_n,
  hc595_if.slave bus
);

  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] shreg_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              shcp_reg;
  logic              ds_reg;

  logic bit_start;
  logic shcp_rise;
  logic phase_last;

  hc595_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk        (clk),
    .srst       (rst_n),
    .en         (state_reg == SHIFT),
    .bit_start  (bit_start),
    .shcp_rise  (shcp_rise),
    .phase_last (phase_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:  state_next = SHIFT;
      SHIFT: begin
        // Leave on the final phase of the last bit so shcp is still high
        // for its full half period before GAP pulls it low.
        if (phase_last && (bit_cnt_reg == BIT_W'(DATA_W - 1))) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Datapath: shift register, counters and pin registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      shcp_reg    <= 1'b0;
      ds_reg      <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          shreg_reg   <= bus.din;
          bit_cnt_reg <= '0;
          gap_cnt_reg <= '0;
          shcp_reg    <= 1'b0;
          ds_reg      <= 1'b0;
        end
        SHIFT: begin
          if (bit_start) begin
            ds_reg    <= shreg_reg[DATA_W-1];
            shreg_reg <= {shreg_reg[DATA_W-2:0], 1'b0};
            shcp_reg  <= 1'b0;
          end
          if (shcp_rise) begin
            shcp_reg <= 1'b1;
          end
          if (phase_last) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          shcp_reg    <= 1'b0;
          ds_reg      <= 1'b0;
          gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        default: begin
          shcp_reg <= 1'b0;
          ds_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shcp = shcp_reg;
  assign bus.ds   = ds_reg;

endmodule

// File: tb/tb_hc595.sv
module tb_hc595;

  localparam int DW  = 16;
  localparam int DIV = 4;
  localparam int GAP = 16;
  localparam int FRAME = 1 + DW * DIV + GAP;  // 81

  logic clk;
  logic rst_n;
  int   checks_cnt;
  int   errors_cnt;

  hc595_if #(.DATA_W(DW)) bus ();

  hc595 #(
    .DATA_W  (DW),
    .CLK_DIV (DIV),
    .GAP_CYC (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 50 MHz
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Samples n_cyc negedges; sample t follows the posedge E0+t, where E0 is
  // the LOAD edge that captured 'word'. Optionally drives din=new_din at
  // sample change_at (to show the running frame is unaffected).
  task automatic run_frame(input string name, input logic [DW-1:0] word, input int n_cyc,
                           input int change_at, input logic [DW-1:0] new_din);
    logic [DW-1:0] rise_bits;
    logic [1:0]    exp_pins;
    logic          prev_shcp;
    int            rises;
    int            high_len;
    int            k;
    int            p;
    rise_bits = '0;
    prev_shcp = 1'b0;
    rises     = 0;
    high_len  = 0;
    for (int t = 0; t < n_cyc; t++) begin
      @(negedge clk);
      if (t == change_at) bus.din = new_din;
      exp_pins = 2'b00;
      if (t >= 1 && t <= DW * DIV) begin
        k = (t - 1) / DIV;
        p = (t - 1) % DIV;
        exp_pins = {(p >= DIV / 2), word[DW-1-k]};
      end
      check($sformatf("%s t=%0d {shcp,ds}", name, t), 32'({bus.shcp, bus.ds}), 32'(exp_pins));
      if (bus.shcp && !prev_shcp) begin
        rises++;
        rise_bits = {rise_bits[DW-2:0], bus.ds};
      end
      if (bus.shcp) begin
        high_len++;
      end else begin
        if (prev_shcp) check($sformatf("%s t=%0d shcp high len", name, t), 32'(high_len), 32'(DIV / 2));
        high_len = 0;
      end
      prev_shcp = bus.shcp;
    end
    if (n_cyc == FRAME) begin
      check($sformatf("%s rise count", name), 32'(rises), 32'(DW));
      check($sformatf("%s ds at rises", name), 32'(rise_bits), 32'(word));
    end
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    bus.din    = 16'hCFB3;
    rst_n      = 1'b1;

    // Reset held for 3 cycles: pins stay low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset cyc%0d shcp", i), 32'(bus.shcp), 32'd0);
      check($sformatf("reset cyc%0d ds", i), 32'(bus.ds), 32'd0);
    end
    rst_n = 1'b0;  // next posedge is the first LOAD

    // ds at rises 1,1,0,0,1,1,1,1,1,0,1,1,0,0,1,1 == 16'b1100_1111_1011_0011
    run_frame("frameA", 16'b1100_1111_1011_0011, FRAME, -1, 16'h0);
    run_frame("frameB", 16'hCFB3, FRAME, -1, 16'h0);
    // din -> 12 mid-SHIFT; this frame still carries CFB3.
    run_frame("frameC", 16'hCFB3, FRAME, 30, 16'd12);
    // 12 zeros then 1,1,0,0; din restored mid-frame for later frames.
    run_frame("frameD", 16'b0000_0000_0000_1100, FRAME, 10, 16'hCFB3);
    // Partial frame, then a 1-cycle reset mid-SHIFT.
    run_frame("frameE", 16'hCFB3, 20, -1, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset shcp", 32'(bus.shcp), 32'd0);
    check("midreset ds", 32'(bus.ds), 32'd0);
    rst_n = 1'b0;
    run_frame("frameF", 16'hCFB3, FRAME, -1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
